// File: rtl/dict_encoder_pkg.sv
// Shared definitions for the dictionary encoder: the controller state
// encoding (also used by the vocab walker) and the NUL character code.
package dict_encoder_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WORD   = 4'd1,
        CMP    = 4'd2,
        SKIPK  = 4'd3,
        SKIPV  = 4'd4,
        EMITV  = 4'd5,
        COPYW  = 4'd6,
        FINISH = 4'd7,
        DONE   = 4'd8
    } state_t;

    // Code of the string terminator character.
    localparam int NUL_CODE = 0;

endpackage

// File: rtl/dict_encoder_vocab_lookup.sv
// Vocab walker: compares one input word against successive (key,value)
// entries. Each character costs one read-issue cycle and one compare cycle.
// Reports a one-cycle hit (with value start and post-word address) or miss.
// Uses states IDLE, CMP, SKIPK, SKIPV of state_t; exposed on 'state'.
module vocab_lookup
    import dict_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] word_addr,
    input  logic [ADDR_WIDTH-1:0] vocab_base,
    input  logic [ADDR_WIDTH-1:0] vocab_last,
    input  logic [DATA_WIDTH-1:0] in_rdata,
    input  logic [DATA_WIDTH-1:0] vocab_rdata,
    output logic [ADDR_WIDTH-1:0] in_addr,
    output logic [ADDR_WIDTH-1:0] vocab_addr,
    output logic                  hit,
    output logic                  miss,
    output logic [ADDR_WIDTH-1:0] val_addr,
    output logic [ADDR_WIDTH-1:0] next_wp,
    output state_t                state
);

    localparam logic [DATA_WIDTH-1:0] NUL = DATA_WIDTH'(NUL_CODE);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                state_n;
    logic                  chk, chk_n;     // 0: issue reads, 1: compare returned data
    logic [ADDR_WIDTH-1:0] ws, ws_n;       // word start
    logic [ADDR_WIDTH-1:0] ip, ip_n;       // input pointer
    logic [ADDR_WIDTH-1:0] vp, vp_n;       // vocab pointer

    assign in_addr    = ip;
    assign vocab_addr = vp;

    // Walker state and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            chk   <= 1'b0;
            ws    <= '0;
            ip    <= '0;
            vp    <= '0;
        end else begin
            state <= state_n;
            chk   <= chk_n;
            ws    <= ws_n;
            ip    <= ip_n;
            vp    <= vp_n;
        end
    end

    // Compare/skip walk; a pointer past vocab_last or an empty key ends in miss.
    always_comb begin
        state_n  = state;
        chk_n    = chk;
        ws_n     = ws;
        ip_n     = ip;
        vp_n     = vp;
        hit      = 1'b0;
        miss     = 1'b0;
        val_addr = vp + ONE;
        next_wp  = ip + ONE;
        case (state)
            IDLE: begin
                if (start) begin
                    ws_n    = word_addr;
                    ip_n    = word_addr;
                    vp_n    = vocab_base;
                    chk_n   = 1'b0;
                    state_n = CMP;
                end
            end
            CMP: begin
                if (!chk) begin
                    if (vp > vocab_last) begin
                        miss    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        chk_n = 1'b1;
                    end
                end else begin
                    chk_n = 1'b0;
                    if (ip == ws && vocab_rdata == NUL) begin
                        miss    = 1'b1;
                        state_n = IDLE;
                    end else if (vocab_rdata == in_rdata) begin
                        if (vocab_rdata == NUL) begin
                            hit     = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ip_n = ip + ONE;
                            vp_n = vp + ONE;
                        end
                    end else begin
                        // Key already terminated here: next char starts the value.
                        vp_n    = vp + ONE;
                        state_n = (vocab_rdata == NUL) ? SKIPV : SKIPK;
                    end
                end
            end
            SKIPK, SKIPV: begin
                if (!chk) begin
                    if (vp > vocab_last) begin
                        miss    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        chk_n = 1'b1;
                    end
                end else begin
                    chk_n = 1'b0;
                    vp_n  = vp + ONE;
                    if (vocab_rdata == NUL) begin
                        if (state == SKIPK) begin
                            state_n = SKIPV;
                        end else begin
                            ip_n    = ws;
                            state_n = CMP;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/dict_encoder.sv
// Dictionary encoder top: word pointer, output writer, overflow check and
// counters around the vocab_lookup walker.
// Optional feature macro ENC_STATS_EN adds saturating hit_cnt/miss_cnt ports.
// Handshake: cs is a start request honoured only while not busy (IDLE/DONE);
// done is a level that holds until the next accepted cs.
module dict_encoder
    import dict_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH-1:0] vocab_base,
    input  logic [ADDR_WIDTH-1:0] vocab_last,
    input  logic [ADDR_WIDTH-1:0] out_base,
    input  logic [ADDR_WIDTH-1:0] out_last,
    output logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_rdata,
    output logic [ADDR_WIDTH-1:0] vocab_addr,
    input  logic [DATA_WIDTH-1:0] vocab_rdata,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic                  out_we,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] word_cnt,
`ifdef ENC_STATS_EN
    output logic [ADDR_WIDTH-1:0] hit_cnt,
    output logic [ADDR_WIDTH-1:0] miss_cnt,
`endif
    output state_t                dbg_state,
    output state_t                dbg_lk_state
);

    localparam logic [DATA_WIDTH-1:0] NUL = DATA_WIDTH'(NUL_CODE);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                state, state_n;
    logic                  accept;
    logic                  wchk, wchk_n;   // WORD: 0 issue read, 1 test char
    logic                  pend, pend_n;   // read data returning this cycle
    logic                  err_n;
    logic [ADDR_WIDTH-1:0] wp, wp_n, rp, rp_n, op, op_n, nwp, nwp_n, word_cnt_n;
    logic [ADDR_WIDTH-1:0] vbase, vlast, olast;
    logic [DATA_WIDTH-1:0] src_data;

    logic                  lk_start, lk_hit, lk_miss;
    logic [ADDR_WIDTH-1:0] lk_in_addr, lk_vocab_addr, lk_val_addr, lk_next_wp;

    vocab_lookup #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lookup (
        .clk         (clk),
        .rst         (rst),
        .start       (lk_start),
        .word_addr   (wp),
        .vocab_base  (vbase),
        .vocab_last  (vlast),
        .in_rdata    (in_rdata),
        .vocab_rdata (vocab_rdata),
        .in_addr     (lk_in_addr),
        .vocab_addr  (lk_vocab_addr),
        .hit         (lk_hit),
        .miss        (lk_miss),
        .val_addr    (lk_val_addr),
        .next_wp     (lk_next_wp),
        .state       (dbg_lk_state)
    );

    assign dbg_state  = state;
    assign busy       = !(state == IDLE || state == DONE);
    assign done       = (state == DONE);
    assign out_addr   = op;
    assign src_data   = (state == EMITV) ? vocab_rdata : in_rdata;
    assign in_addr    = (state == CMP) ? lk_in_addr : (state == COPYW) ? rp : wp;
    assign vocab_addr = (state == EMITV) ? rp : lk_vocab_addr;

    // Controller state, pointers and result registers; bases latched on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wchk     <= 1'b0;
            pend     <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            op       <= '0;
            nwp      <= '0;
            err      <= 1'b0;
            word_cnt <= '0;
            vbase    <= '0;
            vlast    <= '0;
            olast    <= '0;
        end else begin
            state    <= state_n;
            wchk     <= wchk_n;
            pend     <= pend_n;
            wp       <= wp_n;
            rp       <= rp_n;
            op       <= op_n;
            nwp      <= nwp_n;
            err      <= err_n;
            word_cnt <= word_cnt_n;
            if (accept) begin
                vbase <= vocab_base;
                vlast <= vocab_last;
                olast <= out_last;
            end
        end
    end

    // Next-state logic and output write strobe with overflow suppression.
    always_comb begin
        state_n    = state;
        wchk_n     = wchk;
        pend_n     = pend;
        wp_n       = wp;
        rp_n       = rp;
        op_n       = op;
        nwp_n      = nwp;
        err_n      = err;
        word_cnt_n = word_cnt;
        accept     = 1'b0;
        lk_start   = 1'b0;
        out_we     = 1'b0;
        out_wdata  = '0;
        case (state)
            IDLE, DONE: begin
                if (cs) begin
                    accept     = 1'b1;
                    wp_n       = in_base;
                    op_n       = out_base;
                    err_n      = 1'b0;
                    word_cnt_n = '0;
                    wchk_n     = 1'b0;
                    state_n    = WORD;
                end
            end
            WORD: begin
                if (!wchk) begin
                    wchk_n = 1'b1;
                end else begin
                    wchk_n = 1'b0;
                    if (in_rdata == NUL) begin
                        state_n = FINISH;
                    end else begin
                        lk_start = 1'b1;
                        state_n  = CMP;
                    end
                end
            end
            CMP: begin
                if (lk_hit) begin
                    nwp_n   = lk_next_wp;
                    rp_n    = lk_val_addr;
                    pend_n  = 1'b0;
                    state_n = EMITV;
                end else if (lk_miss) begin
                    rp_n    = wp;
                    pend_n  = 1'b0;
                    state_n = COPYW;
                end
            end
            EMITV, COPYW: begin
                // Reads are issued every cycle; data arrives one cycle later.
                rp_n   = rp + ONE;
                pend_n = 1'b1;
                if (pend) begin
                    if (op > olast) begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        out_we    = 1'b1;
                        out_wdata = src_data;
                        op_n      = op + ONE;
                        if (src_data == NUL) begin
                            word_cnt_n = word_cnt + ONE;
                            wp_n       = (state == EMITV) ? nwp : rp;
                            wchk_n     = 1'b0;
                            state_n    = WORD;
                        end
                    end
                end
            end
            FINISH: begin
                if (op > olast) begin
                    err_n = 1'b1;
                end else begin
                    out_we = 1'b1;
                    op_n   = op + ONE;
                end
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef ENC_STATS_EN
    // Saturating hit/miss counters, cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (lk_hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + ONE;
            if (lk_miss && miss_cnt != '1)
                miss_cnt <= miss_cnt + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_dict_encoder.sv
// Bench for dict_encoder: SRAM models, directed word streams, a write
// scoreboard fed at stimulus time and drained by an output monitor.
module tb_dict_encoder;
  import dict_encoder_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0;
  logic [AW-1:0] in_base = '0, vocab_base = '0, vocab_last = '0, out_base = '0, out_last = '0;
  logic [AW-1:0] in_addr, vocab_addr, out_addr, word_cnt;
  logic [DW-1:0] in_rdata = '0, vocab_rdata = '0, out_wdata;
  logic          out_we, busy, done, err;
  state_t        dbg_state, dbg_lk_state;
`ifdef ENC_STATS_EN
  logic [AW-1:0] hit_cnt, miss_cnt;
`endif

  logic [DW-1:0] in_mem[256];
  logic [DW-1:0] vocab_mem[256];
  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit sb_en = 1'b1;

  dict_encoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .cs(cs),
    .in_base(in_base), .vocab_base(vocab_base), .vocab_last(vocab_last),
    .out_base(out_base), .out_last(out_last),
    .in_addr(in_addr), .in_rdata(in_rdata),
    .vocab_addr(vocab_addr), .vocab_rdata(vocab_rdata),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_we(out_we),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt),
`ifdef ENC_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .dbg_state(dbg_state), .dbg_lk_state(dbg_lk_state)
  );

  // clock
  always #5 clk = ~clk;

  // 1-cycle read SRAMs
  always @(posedge clk) begin
    in_rdata    <= in_mem[in_addr];
    vocab_rdata <= vocab_mem[vocab_addr];
  end

  // monitor: every write is matched against the expected queue
  always @(negedge clk) begin
    if (!rst && out_we && sb_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected actual=%0h:%0h required=no write", out_addr, out_wdata);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({out_addr, out_wdata} !== e) begin
          failures++;
          $display("FAIL write actual=%0h:%0h required=%0h:%0h", out_addr, out_wdata,
                   e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // '.' in the strings stands for NUL
  function automatic logic [DW-1:0] chr(input string s, input int i);
    return (s[i] == ".") ? '0 : DW'(s[i]);
  endfunction

  task automatic load_in(input logic [AW-1:0] base, input string s);
    for (int i = 0; i < s.len(); i++) in_mem[base + AW'(i)] = chr(s, i);
  endtask

  task automatic push_exp(input logic [AW-1:0] base, input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({base + AW'(i), chr(s, i)});
  endtask

  task automatic start(input logic [AW-1:0] ib);
    @(negedge clk);
    in_base = ib;
    cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic run(input string name, input logic [AW-1:0] ib, input int exp_wc,
                     input int exp_err, input int exp_hit, input int exp_miss, input bit dup_cs);
    int n;
    start(ib);
    if (dup_cs) begin
      repeat (3) @(negedge clk);
      in_base = 8'h99;
      cs = 1'b1;
      @(negedge clk);
      cs = 1'b0;
    end
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " exp_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({name, " word_cnt"}, 32'(word_cnt), 32'(exp_wc));
    check({name, " err"}, 32'(err), 32'(exp_err));
`ifdef ENC_STATS_EN
    check({name, " hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
    check({name, " miss_cnt"}, 32'(miss_cnt), 32'(exp_miss));
`else
    if (exp_hit + exp_miss < 0) $display("unreachable");
`endif
  endtask

  initial begin
    string xs;
    int n;
    for (int i = 0; i < 256; i++) begin
      in_mem[i] = '0;
      vocab_mem[i] = '0;
    end
    xs = "ab.X.cd.YZ..";
    for (int i = 0; i < xs.len(); i++) vocab_mem[i] = chr(xs, i);
    vocab_base = 8'h00;
    vocab_last = 8'd15;
    out_base   = 8'h40;
    out_last   = 8'h4F;

    // reset state
    repeat (3) @(negedge clk);
    check("rst in_addr", 32'(in_addr), 32'd0);
    check("rst vocab_addr", 32'(vocab_addr), 32'd0);
    check("rst out_addr", 32'(out_addr), 32'd0);
    check("rst out_we", 32'(out_we), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;

    // single hit
    load_in(8'h80, "ab..");
    push_exp(8'h40, "X..");
    run("hit", 8'h80, 1, 0, 1, 0, 1'b0);

    // hit then miss
    load_in(8'h80, "cd.q..");
    push_exp(8'h40, "YZ.q..");
    run("hit_miss", 8'h80, 2, 0, 1, 1, 1'b0);

    // word is a prefix of a key
    load_in(8'h80, "a..");
    push_exp(8'h40, "a..");
    run("prefix_word", 8'h80, 1, 0, 0, 1, 1'b0);

    // key is a prefix of the word
    load_in(8'h80, "abc..");
    push_exp(8'h40, "abc..");
    run("prefix_key", 8'h80, 1, 0, 0, 1, 1'b0);

    // overflow: only 0x40..0x4F may be written
    xs = "";
    for (int i = 0; i < 19; i++) xs = {xs, "x"};
    load_in(8'h80, {xs, ".."});
    push_exp(8'h40, "xxxxxxxxxxxxxxxx");
    run("overflow", 8'h80, 0, 1, 0, 1, 1'b0);

    // input wraps past the top of the address space
    load_in(8'hFE, "ab..");
    push_exp(8'h40, "X..");
    run("wrap", 8'hFE, 1, 0, 1, 0, 1'b0);

    // second cs while busy is ignored
    load_in(8'h80, "cd.q..");
    push_exp(8'h40, "YZ.q..");
    run("dup_cs", 8'h80, 2, 0, 1, 1, 1'b1);

    // reset during value emission
    sb_en = 1'b0;
    load_in(8'h80, "cd..");
    start(8'h80);
    n = 0;
    while (!(dbg_state == EMITV && out_we) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst reach_emitv", 32'(dbg_state), 32'(EMITV));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst out_we", 32'(out_we), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst done", 32'(done), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;

    // clean rerun after the abort
    load_in(8'h80, "ab..");
    push_exp(8'h40, "X..");
    run("rerun", 8'h80, 1, 0, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
